pipelined_cskip_adder: RTL and testbench
========================================

Name: pipelined_cskip_adder

Overview:
Parametrised, pipelined carry-skip adder/subtractor with valid/ready handshake. It is the successor to the team's fixed 64-bit combinational carry-skip adder.
- Operand width, skip-block size and pipeline depth are configurable.
- Adds carry-in, a subtract mode and backpressure.
- Sits in the datapath wherever a wide add must close timing at full clock rate.

Parameters:
WIDTH, 64, operand/sum width in bits; must be a multiple of BLOCK*STAGES
BLOCK, 4, bits per ripple-carry skip block
STAGES, 4, pipeline stages; each stage adds WIDTH/STAGES bits

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands presented
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (ignored when sub=1)
sub  input  1  1 = compute a - b
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry-out (for sub: 1 = no borrow)

Behaviour:
- Operand conditioning:
  - Effective B = sub ? ~b : b.
  - Effective carry-in = sub ? 1 : cin.
  - Result = a + effB + effCin, modulo 2^WIDTH; cout is bit WIDTH.
- Slice structure:
  - Stage k (0..STAGES-1) handles bits [k*W/S +: W/S].
  - Inside each slice, BLOCK-bit ripple blocks are chained with skip logic: block carry-out = (all propagate bits set) ? block carry-in : ripple carry-out.
  - The inter-stage carry is registered.
- Input skew: not-yet-consumed operand slices travel with the pipeline; finished sum slices are carried forward so the output is aligned.
- Latency: exactly STAGES cycles from accepted transfer (in_valid & in_ready) to out_valid, with no stall.
- Throughput: one result per cycle.
- Per-stage valid bits v[0..STAGES-1]; out_valid = v[STAGES-1].
- Global advance: adv = !out_valid | out_ready; in_ready = adv.
  - When adv=1, every stage register loads its predecessor. Stage 0 loads in_valid & in_ready.
  - When adv=0, all stage registers hold; sum and cout stay stable while out_valid=1 and out_ready=0.
- Bubbles propagate as v=0. Data registers of invalid stages may update freely; only the valid bits matter.
- Simultaneous input accept and output drain in one cycle is allowed; occupancy is unchanged.
- Reset (async, rst_n=0):
  - all v=0, out_valid=0, sum=0, cout=0, in_ready=1 after reset is released;
  - reset mid-operation discards all in-flight results.
- Degenerate case STAGES=1: a single register stage, latency 1.

Optional Feature:
- Macro PCSA_OVERFLOW_EN.
- When defined:
  - adds output port ovf (1 bit), the signed two's-complement overflow of the effective addition: carry into MSB XOR carry out of MSB;
  - ovf is registered and aligned with sum, resets to 0 and holds under stall.
- When undefined, the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package pcsa_pkg holds:
  - default WIDTH/BLOCK/STAGES constants;
  - a localparam function computing slice width;
  - an elaboration check that WIDTH % (BLOCK*STAGES) == 0.
- One natural sub-module: cskip_block, a combinational BLOCK-wide ripple adder with propagate-AND skip mux (inputs a, b, ci; outputs s, co). It is instantiated WIDTH/BLOCK times via generate.

Test Plan:
- Full propagate: WIDTH=64, a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0, sub=0 → sum=0x0, cout=1, out_valid exactly 4 cycles after acceptance.
- Subtract with borrow: a=5, b=7, sub=1 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0. Also a=7, b=5, sub=1 → sum=2, cout=1.
- Streaming: 100 back-to-back random operands with out_ready=1 → one result per cycle, in order, all matching the reference model a+b+cin.
- Backpressure: out_ready=0 while 6 operands are offered → exactly 4 accepted, then in_ready=0. sum/cout stay stable while stalled. Raising out_ready drains 4 results in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 with 3 valid stages → out_valid=0 and sum=0 immediately (asynchronously). No stale results appear after release.
- With PCSA_OVERFLOW_EN: a=0x7FFF_FFFF_FFFF_FFFF, b=1 → ovf=1, sum=0x8000_0000_0000_0000. a=1, b=1 → ovf=0.

Source files
------------

// File: rtl/pcsa_pkg.sv
// pcsa_pkg: shared defaults and configuration helpers for pipelined_cskip_adder.
package pcsa_pkg;
  localparam int DEF_WIDTH  = 64;
  localparam int DEF_BLOCK  = 4;
  localparam int DEF_STAGES = 4;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int block, input int stages);
    return (width % (block * stages)) == 0;
  endfunction
endpackage

// File: rtl/pipelined_cskip_adder_cskip_block.sv
// cskip_block: combinational N-bit ripple adder whose carry-out bypasses the ripple when all bits propagate.
module cskip_block
  import pcsa_pkg::*;
#(
  parameter int N = DEF_BLOCK
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N-1:0] p;
  logic [N:0]   c;

  assign p = a ^ b;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < N; i++) begin
      s[i]   = p[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
    end
  end

  assign co = &p ? ci : c[N];
endmodule

// File: rtl/pipelined_cskip_adder.sv
// pipelined_cskip_adder: STAGES-deep carry-skip adder/subtractor with a valid/ready handshake.
// Define PCSA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module pipelined_cskip_adder
  import pcsa_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int BLOCK  = DEF_BLOCK,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PCSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);
  localparam int SW = slice_w(WIDTH, STAGES);
  localparam int NB = SW / BLOCK;

  logic adv;

  if (!cfg_ok(WIDTH, BLOCK, STAGES)) begin : g_bad_cfg
    $error("pipelined_cskip_adder: WIDTH must be a multiple of BLOCK*STAGES");
  end

  // Each stage adds its slice; unconsumed operand bits shift along and finished sum bits accumulate.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int RI = WIDTH - k * SW;
    logic [RI-1:0]         a_in;
    logic [RI-1:0]         b_in;
    logic                  c_in;
    logic                  v_in;
    logic [NB:0]           ch;
    logic [SW-1:0]         s_blk;
    logic [(k+1)*SW-1:0]   s_n;
    logic [(k+1)*SW-1:0]   s_q;
    logic                  c_n;
    logic                  c_q;
    logic                  v_q;

    if (k == 0) begin : g_head
      assign a_in = a;
      assign b_in = sub ? ~b : b;
      assign c_in = sub | cin;
      assign v_in = in_valid & in_ready;
      assign s_n  = s_blk;
    end else begin : g_body
      assign a_in = g_stage[k-1].g_fwd.a_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
      assign s_n  = {s_blk, g_stage[k-1].s_q};
    end

    assign ch[0] = c_in;
    for (genvar j = 0; j < NB; j++) begin : g_blk
      cskip_block #(.N(BLOCK)) u_blk (
        .a  (a_in[j*BLOCK +: BLOCK]),
        .b  (b_in[j*BLOCK +: BLOCK]),
        .ci (ch[j]),
        .s  (s_blk[j*BLOCK +: BLOCK]),
        .co (ch[j+1])
      );
    end
    assign c_n = ch[NB];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= c_n;
        s_q <= s_n;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RI-SW-1:0] a_q;
      logic [RI-SW-1:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[RI-1:SW];
          b_q <= b_in[RI-1:SW];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;

`ifdef PCSA_OVERFLOW_EN
  // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ s.
  logic ovf_n;
  assign ovf_n = g_stage[STAGES-1].a_in[SW-1] ^ g_stage[STAGES-1].b_in[SW-1]
               ^ g_stage[STAGES-1].s_blk[SW-1] ^ g_stage[STAGES-1].c_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ovf <= 1'b0;
    else if (adv) ovf <= ovf_n;
  end
`endif
endmodule

// File: tb/tb_pipelined_cskip_adder.sv
// tb_pipelined_cskip_adder: directed self-checking bench for the default 64-bit, 4-stage configuration.
module tb_pipelined_cskip_adder;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PCSA_OVERFLOW_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipelined_cskip_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PCSA_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum: got %h want 0", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_full_propagate();
    out_ready = 1'b1;
    a = '1; b = 64'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (out_valid !== 1'(i == 4)) begin
        errors++; $display("FAIL latency_edge%0d: out_valid got %b want %b", i, out_valid, i == 4);
      end
      if (i < 4) tick();
    end
    checks++; if (sum !== 64'h0) begin errors++; $display("FAIL propagate_sum: got %h want 0", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL propagate_cout: got %b want 1", cout); end
    drain();
  endtask

  task automatic test_subtract();
    logic [W-1:0] ta [2] = '{64'd5, 64'd7};
    logic [W-1:0] tb [2] = '{64'd7, 64'd5};
    logic         tc [2] = '{1'b1, 1'b0};
    logic [W-1:0] es [2] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd2};
    logic         ec [2] = '{1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = ta[i]; b = tb[i]; cin = tc[i]; sub = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub%0d_valid: got %b want 1", i, out_valid); end
      checks++; if (sum !== es[i]) begin errors++; $display("FAIL sub%0d_sum: got %h want %h", i, sum, es[i]); end
      checks++; if (cout !== ec[i]) begin errors++; $display("FAIL sub%0d_cout: got %b want %b", i, cout, ec[i]); end
      drain();
    end
    sub = 1'b0; cin = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W:0] q [$];
    logic [W:0] exp;
    int got = 0, first = -1, last = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 130 && got < 100; cyc++) begin
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra: unexpected result %h at cycle %0d", sum, cyc);
        end else begin
          exp = q.pop_front();
          if ({cout, sum} !== exp) begin
            errors++; $display("FAIL stream_result%0d: got %h want %h", got, {cout, sum}, exp);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (cyc < 100) begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        q.push_back(sub ? {1'b0, a} + {1'b0, ~b} + 65'd1 : {1'b0, a} + {1'b0, b} + {64'd0, cin});
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0; sub = 1'b0; cin = 1'b0;
    checks++; if (got !== 100) begin errors++; $display("FAIL stream_count: got %0d want 100", got); end
    checks++; if (last - first !== 99) begin errors++; $display("FAIL stream_rate: span %0d want 99", last - first); end
    drain();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] bb = 64'hF0F0_0000_0000_0001;
    logic [W-1:0] held_s;
    logic         held_c, rdy;
    logic [W:0]   exp;
    int acc = 0, n = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      a = 64'h0F0F_0000_0000_0000 + 64'(acc); b = bb; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      rdy = in_ready;
      tick();
      if (rdy) acc++;
    end
    checks++; if (acc !== 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", acc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    checks++; if (sum !== 64'hFFFF_0000_0000_0001) begin errors++; $display("FAIL bp_head: got %h want ffff000000000001", sum); end
    held_s = sum; held_c = cout;
    repeat (3) begin
      tick();
      checks++;
      if (sum !== held_s || cout !== held_c || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_stable: got %b/%h/%b want 1/%h/%b", out_valid, sum, cout, held_s, held_c);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        exp = {1'b0, 64'h0F0F_0000_0000_0000 + 64'(n)} + {1'b0, bb};
        checks++;
        if ({cout, sum} !== exp) begin errors++; $display("FAIL bp_drain%0d: got %h want %h", n, {cout, sum}, exp); end
        n++;
      end
      tick();
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL bp_drain_count: got %0d want 4", n); end
  endtask

  task automatic test_reset_midflight();
    logic seen = 1'b0;
    out_ready = 1'b0; b = 64'h1111; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 64'h1234 + 64'(i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || sum !== 64'h2345) begin errors++; $display("FAIL mid_pre: got %b/%h want 1/2345", out_valid, sum); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    checks++; if (sum !== '0 || cout !== 1'b0) begin errors++; $display("FAIL mid_data: got %h/%b want 0/0", sum, cout); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_stale: stale result after reset release"); end
  endtask

`ifdef PCSA_OVERFLOW_EN
  task automatic test_overflow();
    logic [W-1:0] ta [2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1};
    logic [W-1:0] es [2] = '{64'h8000_0000_0000_0000, 64'd2};
    logic         eo [2] = '{1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = ta[i]; b = 64'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      checks++; if (sum !== es[i]) begin errors++; $display("FAIL ovf%0d_sum: got %h want %h", i, sum, es[i]); end
      checks++; if (ovf !== eo[i]) begin errors++; $display("FAIL ovf%0d_flag: got %b want %b", i, ovf, eo[i]); end
      drain();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_propagate();
    test_subtract();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
`ifdef PCSA_OVERFLOW_EN
    test_overflow();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
